enum_cmd_sequencer: RTL and testbench
=====================================

// Module: enum_cmd_sequencer
// PURPOSE
//   Consumes typed commands (mode enum + opcode enum) and expands each RUN command into a
//   counted stream of step beats over a valid/ready interface.
//   Sits directly downstream of the enum-typed command source; turns its mode/op values
//   into sequenced work for the execution stage.
// PARAMETERS
//   LEN_W  8  width of cmd_len and step_idx; max run length 2**LEN_W-1
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   cmd_valid   in   1      command offered
//   cmd_ready   out  1      command accepted when cmd_valid && cmd_ready
//   cmd_mode    in   2      mode_e
//   cmd_op      in   3      op_e
//   cmd_len     in   LEN_W  beat count for OP_RUN
//   abort       in   1      terminate an active run early
//   step_valid  out  1      step beat offered
//   step_ready  in   1      step beat consumed
//   step_idx    out  LEN_W  beat index, 0..len-1
//   step_mode   out  2      mode_e for the beat (equals cur_mode)
//   cur_mode    out  2      currently loaded mode_e
//   busy        out  1      state != S_IDLE
//   done        out  1      1-cycle pulse at end of a run
//   aborted     out  1      valid with done; 1 = run ended by abort
//   err         out  1      1-cycle pulse on an illegal command
// BEHAVIOUR
//   Reset (async, rst_n=0) values:
//     state S_IDLE; cur_mode MODE_A; step_valid 0; step_idx 0; done 0; aborted 0; err 0; busy 0.
//     cmd_ready = (state==S_IDLE), so it reads 1 while in reset.
//   FSM states: S_IDLE, S_RUN, S_DRAIN.
//   S_IDLE, accepted command:
//     OP_NOP: no effect.
//     OP_LOAD: cur_mode <= cmd_mode, visible the next cycle.
//     OP_RUN with len>0: latch len and mode, clear counter, go to S_RUN.
//     OP_RUN with len==0: done=1 and aborted=0 next cycle; stay in S_IDLE.
//     OP_STOP: ignored.
//     Illegal: cmd_op in 3'b100..3'b111, or cmd_mode==MODE_RSVD (2'b11).
//       err=1 next cycle for 1 cycle; no state or cur_mode change.
//       cmd_ready stays 1, so the command is consumed.
//   S_RUN:
//     step_valid=1; step_idx=counter; step_mode=cur_mode.
//     step_idx and step_mode stay stable while step_valid && !step_ready.
//     On beat (step_valid && step_ready): counter++.
//     Beat with counter==len-1 -> S_DRAIN with aborted=0.
//     abort=1 with no beat -> S_DRAIN with aborted=1; step_valid=0 next cycle.
//     abort together with a beat: the beat counts.
//       If that beat was the last one, aborted=0; otherwise aborted=1.
//   S_DRAIN: step_valid=0; done=1 for exactly 1 cycle; aborted held with it; next state S_IDLE.
//   Latency: RUN accepted at cycle T ->
//     step_valid=1, idx=0 at T+1;
//     last beat at cycle L -> done=1 at L+1 -> cmd_ready=1 at L+2.
//   abort outside S_RUN: ignored.
//   The counter never wraps, since idx < len <= 2**LEN_W-1.
//   Reset mid-run: immediate S_IDLE and reset values; no done pulse.
// STRUCTURE
//   Package enum_seq_pkg holds:
//     mode_e: logic[1:0] MODE_A=00, MODE_B=01, MODE_C=10, MODE_RSVD=11.
//     op_e: logic[2:0] OP_NOP=000, OP_LOAD=001, OP_RUN=010, OP_STOP=011.
//     state_e: S_IDLE, S_RUN, S_DRAIN.
//   Every enumerator name in enum_seq_pkg is unique package-wide; the prefixes MODE_/OP_/S_
//   are mandatory.
//   Ports use the package types; import enum_seq_pkg in the module header.
//   No sub-module: FSM plus counter in one module.
// TESTING
//   1. Reset then LOAD mode=MODE_B -> cur_mode=01 next cycle; busy stays 0.
//   2. RUN len=3, step_ready=1 ->
//        step_idx 0,1,2 on three consecutive cycles; done=1 and aborted=0 one cycle later;
//        cmd_ready=1 one cycle after that.
//   3. RUN len=4 with step_ready toggling 1,0,1,0 -> idx holds during stalls; exactly 4 beats.
//   4. RUN len=5 with abort after beat 1 -> no further beats; done=1 with aborted=1.
//      Abort on beat 4 (the last) -> aborted=0.
//   5. op=3'b101, then mode=2'b11 -> err pulses once each; cur_mode and state unchanged.
//      RUN len=0 -> done pulse, no beats.
//   6. rst_n low during a RUN at idx=2 -> all outputs go to reset values immediately; no done.

Source files
------------

// File: rtl/enum_seq_pkg.sv
// Shared types for the enum command sequencer: command mode, opcode and FSM state.
package enum_seq_pkg;

    typedef enum logic [1:0] {
        MODE_A    = 2'b00,
        MODE_B    = 2'b01,
        MODE_C    = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_RUN  = 3'b010,
        OP_STOP = 3'b011
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/enum_cmd_sequencer.sv
// Expands RUN commands into a counted stream of step beats; LOAD updates the current mode.
module enum_cmd_sequencer
    import enum_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  mode_e            cmd_mode,
    input  op_e              cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [LEN_W-1:0] step_idx,
    output mode_e            step_mode,
    output mode_e            cur_mode,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    state_e           r_state;
    state_e           w_next;
    mode_e            r_cur_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_done;
    logic             r_aborted;
    logic             r_err;

    logic [2:0]       w_op_bits;
    logic             w_accept;
    logic             w_illegal;
    logic             w_beat;
    logic             w_last;

    assign w_op_bits = cmd_op;
    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    // Opcodes 100..111 and the reserved mode are rejected but still consumed.
    assign w_illegal = w_op_bits[2] || (cmd_mode == MODE_RSVD);
    assign w_beat    = (r_state == S_RUN) && step_ready;
    assign w_last    = w_beat && (r_cnt == r_len - LEN_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_illegal && (cmd_op == OP_RUN) && (cmd_len != '0)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last || abort) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        step_valid = (r_state == S_RUN);
        busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_mode <= MODE_A;
            r_len      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;

            if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    case (cmd_op)
                        OP_LOAD: r_cur_mode <= cmd_mode;
                        OP_RUN: begin
                            if (cmd_len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_len      <= cmd_len;
                                r_cur_mode <= cmd_mode;
                                r_cnt      <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (w_beat) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end

            // A beat coinciding with abort still counts; only a final beat clears aborted.
            if ((r_state == S_RUN) && (w_next == S_DRAIN)) begin
                r_done    <= 1'b1;
                r_aborted <= !w_last;
            end
        end
    end

    assign step_idx  = r_cnt;
    assign step_mode = r_cur_mode;
    assign cur_mode  = r_cur_mode;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign err       = r_err;

endmodule

// File: tb/tb_enum_cmd_sequencer.sv
// Directed bench for enum_cmd_sequencer with a beat scoreboard and immediate-assertion checks.
module tb_enum_cmd_sequencer;
    import enum_seq_pkg::*;

    localparam int LEN_W = 8;

    typedef struct packed {
        logic [LEN_W-1:0] idx;
        logic [1:0]       mode;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    mode_e            cmd_mode;
    op_e              cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             step_valid;
    logic             step_ready;
    logic [LEN_W-1:0] step_idx;
    mode_e            step_mode;
    mode_e            cur_mode;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;

    int               total;
    int               bad;
    int               beats;
    int               done_cnt;
    beat_t            sb[$];
    logic             prev_stall;
    logic [LEN_W-1:0] prev_idx;
    logic [1:0]       prev_mode;

    enum_cmd_sequencer #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_idx   (step_idx),
        .step_mode  (step_mode),
        .cur_mode   (cur_mode),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic cyc();
        beat_t b;
        @(negedge clk);
        if (prev_stall && step_valid) begin
            check("stall_idx_hold", 32'(step_idx), 32'(prev_idx));
            check("stall_mode_hold", 32'(step_mode), 32'(prev_mode));
        end
        prev_stall = step_valid && !step_ready;
        prev_idx   = step_idx;
        prev_mode  = step_mode;
        if (step_valid && step_ready) begin
            beats++;
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                b = sb.pop_front();
                check("beat_idx", 32'(step_idx), 32'(b.idx));
                check("beat_mode", 32'(step_mode), 32'(b.mode));
            end
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_e op, input mode_e mode, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = mode;
        cmd_len   = len;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_mode  = MODE_A;
        cmd_len   = '0;
    endtask

    task automatic push_beats(input int n, input mode_e mode);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.idx  = LEN_W'(i);
            b.mode = mode;
            sb.push_back(b);
        end
    endtask

    initial begin
        int b0;
        int d0;
        total      = 0;
        bad        = 0;
        beats      = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        prev_idx   = '0;
        prev_mode  = '0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = OP_NOP;
        cmd_mode   = MODE_A;
        cmd_len    = '0;
        abort      = 1'b0;
        step_ready = 1'b0;

        // Reset values
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step_valid", 32'(step_valid), 32'd0);
        check("rst_step_idx", 32'(step_idx), 32'd0);
        check("rst_cur_mode", 32'(cur_mode), 32'(MODE_A));
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. LOAD MODE_B
        send(OP_LOAD, MODE_B, 8'd0);
        check("load_cur_mode", 32'(cur_mode), 32'(MODE_B));
        check("load_busy", 32'(busy), 32'd0);
        cyc();
        check("load_busy_after", 32'(busy), 32'd0);

        // 2. RUN len=3, ready held high
        step_ready = 1'b1;
        b0 = beats;
        push_beats(3, MODE_C);
        send(OP_RUN, MODE_C, 8'd3);
        check("run3_first_valid", 32'(step_valid), 32'd1);
        check("run3_first_idx", 32'(step_idx), 32'd0);
        check("run3_busy", 32'(busy), 32'd1);
        check("run3_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        cyc();
        cyc();
        cyc();
        check("run3_done", 32'(done), 32'd1);
        check("run3_aborted", 32'(aborted), 32'd0);
        check("run3_valid_drain", 32'(step_valid), 32'd0);
        check("run3_cmd_ready_drain", 32'(cmd_ready), 32'd0);
        cyc();
        check("run3_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("run3_done_pulse", 32'(done), 32'd0);
        check("run3_beats", 32'(beats - b0), 32'd3);
        check("run3_sb_empty", 32'(sb.size()), 32'd0);

        // 3. RUN len=4, ready toggling 1,0,1,0
        b0 = beats;
        d0 = done_cnt;
        step_ready = 1'b0;
        push_beats(4, MODE_B);
        send(OP_RUN, MODE_B, 8'd4);
        for (int i = 0; i < 30 && done_cnt == d0; i++) begin
            step_ready = (i % 2 == 0);
            cyc();
        end
        check("run4_done_seen", 32'(done_cnt - d0), 32'd1);
        check("run4_aborted", 32'(aborted), 32'd0);
        check("run4_beats", 32'(beats - b0), 32'd4);
        check("run4_sb_empty", 32'(sb.size()), 32'd0);
        step_ready = 1'b0;
        cyc();
        check("run4_idle", 32'(cmd_ready), 32'd1);

        // 4a. RUN len=5, abort with no beat after beat 1
        step_ready = 1'b1;
        b0 = beats;
        push_beats(2, MODE_A);
        send(OP_RUN, MODE_A, 8'd5);
        cyc();
        cyc();
        step_ready = 1'b0;
        abort      = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_done", 32'(done), 32'd1);
        check("abort_aborted", 32'(aborted), 32'd1);
        check("abort_valid_off", 32'(step_valid), 32'd0);
        step_ready = 1'b1;
        cyc();
        cyc();
        check("abort_beats", 32'(beats - b0), 32'd2);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // 4b. abort on the last beat: the run completes normally
        b0 = beats;
        push_beats(5, MODE_C);
        send(OP_RUN, MODE_C, 8'd5);
        cyc();
        cyc();
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_last_done", 32'(done), 32'd1);
        check("abort_last_aborted", 32'(aborted), 32'd0);
        cyc();
        check("abort_last_beats", 32'(beats - b0), 32'd5);

        // 4c. abort with a non-final beat: beat counts, aborted=1
        b0 = beats;
        push_beats(2, MODE_B);
        send(OP_RUN, MODE_B, 8'd5);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_beat_done", 32'(done), 32'd1);
        check("abort_beat_aborted", 32'(aborted), 32'd1);
        cyc();
        check("abort_beat_beats", 32'(beats - b0), 32'd2);
        check("abort_beat_sb_empty", 32'(sb.size()), 32'd0);

        // abort while idle is ignored
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("idle_abort_done", 32'(done), 32'd0);
        check("idle_abort_busy", 32'(busy), 32'd0);

        // 5. Illegal opcode, then reserved mode
        send(OP_LOAD, MODE_C, 8'd0);
        send(op_e'(3'b101), MODE_A, 8'd3);
        check("illop_err", 32'(err), 32'd1);
        check("illop_cur_mode", 32'(cur_mode), 32'(MODE_C));
        check("illop_busy", 32'(busy), 32'd0);
        check("illop_ready", 32'(cmd_ready), 32'd1);
        cyc();
        check("illop_err_pulse", 32'(err), 32'd0);
        send(OP_RUN, MODE_RSVD, 8'd3);
        check("rsvd_err", 32'(err), 32'd1);
        check("rsvd_cur_mode", 32'(cur_mode), 32'(MODE_C));
        check("rsvd_busy", 32'(busy), 32'd0);
        cyc();
        check("rsvd_err_pulse", 32'(err), 32'd0);

        // NOP and STOP leave mode and state alone
        send(OP_NOP, MODE_B, 8'd0);
        check("nop_cur_mode", 32'(cur_mode), 32'(MODE_C));
        send(OP_STOP, MODE_A, 8'd0);
        check("stop_cur_mode", 32'(cur_mode), 32'(MODE_C));
        check("stop_busy", 32'(busy), 32'd0);

        // RUN len=0: done pulse, no beats
        b0 = beats;
        send(OP_RUN, MODE_B, 8'd0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_aborted", 32'(aborted), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_valid", 32'(step_valid), 32'd0);
        cyc();
        check("len0_done_pulse", 32'(done), 32'd0);
        check("len0_beats", 32'(beats - b0), 32'd0);

        // 6. Reset during a run at idx=2
        step_ready = 1'b1;
        push_beats(2, MODE_B);
        send(OP_RUN, MODE_B, 8'd5);
        cyc();
        cyc();
        check("prerst_idx", 32'(step_idx), 32'd2);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(step_valid), 32'd0);
        check("midrst_idx", 32'(step_idx), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_cur_mode", 32'(cur_mode), 32'(MODE_A));
        check("midrst_done", 32'(done), 32'd0);
        prev_stall = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
